// File: rtl/regfile_rd_seq.sv
// Read-side operand sequencer for the single-read-port regfile_dp storage.
// Takes one rs1/rs2 request, reads both operands over two cycles through the
// single async read port, and returns them together on a valid/ready response.
// It also gates core write-back onto the storage: writes to x0 are dropped,
// and writes to operands that are already captured can be snooped in.
module regfile_rd_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          SNOOP      = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_do,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_di
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  hit1, hit2;

  // Write-back gating: x0 is never written; write path passes straight through.
  always_comb begin
    rf_we    = resetn & wr_en & (wr_addr != '0);
    rf_waddr = wr_addr;
    rf_di    = wr_data;
    hit1     = rf_we && (wr_addr == rs1_q);
    hit2     = rf_we && (wr_addr == rs2_q);
  end

  // Read-data select: the DRAM write lands at the same edge we capture, so a
  // same-cycle write to the address being read is forwarded from wr_data.
  always_comb begin
    if (rf_raddr == '0)
      rd_sel = '0;
    else if (rf_we && (wr_addr == rf_raddr))
      rd_sel = wr_data;
    else
      rd_sel = rf_do;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and handshake/read-address outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_raddr  = '0;
    unique case (state)
      IDLE: begin
        req_ready = resetn;
        if (req_valid)
          state_nxt = RD1;
      end
      RD1: begin
        rf_raddr  = rs1_q;
        state_nxt = RD2;
      end
      RD2: begin
        rf_raddr  = rs2_q;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand address latch and operand capture, with optional snooping of
  // write-back into values that were captured before the write arrived.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            rs1_q <= rs1_addr;
            rs2_q <= rs2_addr;
          end
        end
        RD1: rs1_data <= rd_sel;
        RD2: begin
          rs2_data <= rd_sel;
          if (SNOOP && hit1)
            rs1_data <= wr_data;
        end
        RESP: begin
          if (SNOOP && hit1)
            rs1_data <= wr_data;
          if (SNOOP && hit2)
            rs2_data <= wr_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_rd_seq.sv
// Bench for regfile_rd_seq: two instances (snooping on / off) share stimulus,
// each backed by its own behavioural 32x32 async-read register array.
module tb_regfile_rd_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rsp_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic        req_ready0, req_ready1;
  logic        rsp_valid0, rsp_valid1;
  logic [31:0] rs1_data0, rs1_data1, rs2_data0, rs2_data1;
  logic [4:0]  rf_raddr0, rf_raddr1, rf_waddr0, rf_waddr1;
  logic        rf_we0, rf_we1;
  logic [31:0] rf_di0, rf_di1, rf_do0, rf_do1;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register arrays: synchronous write, asynchronous read.
  always @(posedge clk) if (rf_we0) mem0[rf_waddr0] <= rf_di0;
  always @(posedge clk) if (rf_we1) mem1[rf_waddr1] <= rf_di1;
  assign rf_do0 = mem0[rf_raddr0];
  assign rf_do1 = mem1[rf_raddr1];

  regfile_rd_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SNOOP(1'b0)) u_dut0 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready0),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rs1_data(rs1_data0), .rs2_data(rs2_data0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rf_raddr(rf_raddr0), .rf_do(rf_do0), .rf_we(rf_we0),
    .rf_waddr(rf_waddr0), .rf_di(rf_di0)
  );

  regfile_rd_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SNOOP(1'b1)) u_dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready1),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rs1_data(rs1_data1), .rs2_data(rs2_data1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rf_raddr(rf_raddr1), .rf_do(rf_do1), .rf_we(rf_we1),
    .rf_waddr(rf_waddr1), .rf_di(rf_di1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitors: pop the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (resetn && rsp_valid0 && rsp_ready) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp0_unexpected: got=%08h/%08h expected=none", rs1_data0, rs2_data0);
      end else begin
        e0 = q0.pop_front();
        chk("rsp0_rs1", rs1_data0, e0[63:32]);
        chk("rsp0_rs2", rs2_data0, e0[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && rsp_valid1 && rsp_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp1_unexpected: got=%08h/%08h expected=none", rs1_data1, rs2_data1);
      end else begin
        e1 = q1.pop_front();
        chk("rsp1_rs1", rs1_data1, e1[63:32]);
        chk("rsp1_rs2", rs2_data1, e1[31:0]);
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    #1;
    chk("rf_we", 32'(rf_we1), 32'(a != 5'd0));
    tick();
    wr_en = 1'b0;
  endtask

  task automatic req(input logic [4:0] a1, input logic [4:0] a2, input bit push,
                     input logic [63:0] x0, input logic [63:0] x1, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = 0;
    rs1_addr  = a1;
    rs2_addr  = a2;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready1) begin
        ok = 1'b1;
        if (push) begin
          q0.push_back(x0);
          q1.push_back(x1);
        end
        tick();
        acc = cyc;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_accept_timeout: got=no_accept expected=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got=%0d/%0d pending expected=0", q0.size(), q1.size());
    end
  endtask

  initial begin
    int a1, a2;
    resetn = 1'b0; req_valid = 1'b0; rs1_addr = '0; rs2_addr = '0;
    rsp_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) tick();
    chk("rst_req_ready", 32'(req_ready1), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_rs1_data", rs1_data1, 32'd0);
    chk("rst_rs2_data", rs2_data1, 32'd0);
    chk("rst_raddr", 32'(rf_raddr1), 32'd0);
    resetn = 1'b1;
    tick();
    chk("rel_req_ready", 32'(req_ready1), 32'd1);

    wr(5'd5, 32'h1234_5678);
    wr(5'd20, 32'hDEAD_BEEF);
    wr(5'd8, 32'h8888_8888);
    wr(5'd9, 32'h0000_0009);

    // Reset in RD2: request dropped, outputs cleared.
    req(5'd5, 5'd20, 1'b0, '0, '0, a1);
    tick();
    resetn = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("midrst_rs1_data", rs1_data1, 32'd0);
    chk("midrst_rs2_data", rs2_data1, 32'd0);
    chk("midrst_req_ready", 32'(req_ready1), 32'd0);
    tick();
    resetn = 1'b1;
    #1;
    chk("midrst_rel_ready", 32'(req_ready1), 32'd1);
    tick();

    // Basic read, latency and hold while stalled.
    rsp_ready = 1'b0;
    req(5'd5, 5'd20, 1'b1, {32'h1234_5678, 32'hDEAD_BEEF}, {32'h1234_5678, 32'hDEAD_BEEF}, a1);
    chk("lat_rd1_valid", 32'(rsp_valid1), 32'd0);
    tick();
    chk("lat_rd2_valid", 32'(rsp_valid1), 32'd0);
    tick();
    chk("lat_resp_valid", 32'(rsp_valid1), 32'd1);
    repeat (2) tick();
    chk("hold_valid", 32'(rsp_valid1), 32'd1);
    chk("hold_rs1", rs1_data1, 32'h1234_5678);
    chk("hold_rs2", rs2_data1, 32'hDEAD_BEEF);
    chk("hold_req_ready", 32'(req_ready1), 32'd0);
    rsp_ready = 1'b1;
    drain();

    // x0: write suppressed, reads as zero.
    wr(5'd0, 32'hFFFF_FFFF);
    req(5'd0, 5'd0, 1'b1, 64'd0, 64'd0, a1);
    drain();

    // Same-cycle bypass while reading rs1.
    req(5'd7, 5'd8, 1'b1, {32'hA5A5_A5A5, 32'h8888_8888}, {32'hA5A5_A5A5, 32'h8888_8888}, a1);
    wr(5'd7, 32'hA5A5_A5A5);
    drain();

    // rs1==rs2, write during RD2: rs2 bypassed, rs1 snooped only when enabled.
    req(5'd9, 5'd9, 1'b1, {32'h0000_0009, 32'h0000_0077}, {32'h0000_0077, 32'h0000_0077}, a1);
    tick();
    wr(5'd9, 32'h0000_0077);
    drain();

    // Back-to-back with rsp_ready held high.
    req(5'd5, 5'd20, 1'b1, {32'h1234_5678, 32'hDEAD_BEEF}, {32'h1234_5678, 32'hDEAD_BEEF}, a1);
    req(5'd20, 5'd5, 1'b1, {32'hDEAD_BEEF, 32'h1234_5678}, {32'hDEAD_BEEF, 32'h1234_5678}, a2);
    chk("b2b_gap", 32'(a2 - a1), 32'd4);
    drain();

    // Snoop during RESP.
    rsp_ready = 1'b0;
    req(5'd5, 5'd20, 1'b1, {32'h1234_5678, 32'hDEAD_BEEF}, {32'h1234_5678, 32'h0000_0001}, a1);
    repeat (2) tick();
    wr(5'd20, 32'h0000_0001);
    chk("snoop1_rs2", rs2_data1, 32'h0000_0001);
    chk("snoop0_rs2", rs2_data0, 32'hDEAD_BEEF);
    chk("snoop1_rs1", rs1_data1, 32'h1234_5678);
    rsp_ready = 1'b1;
    drain();

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
